// File: rtl/mem_client_arb.sv
// ---------------------------------------------------------------------------
// mem_client_arb
//
// Grants up to NUM_CLIENTS compute clients access to the single DDR<->SRAM
// transfer engine. An optional high-priority client always wins when it is
// requesting. All other clients are served round-robin. The granted command
// is offered to mem_ctrl with a valid/ready handshake. The arbiter then waits
// for the transfer-done pulse before it arbitrates again. A watchdog raises a
// sticky error if the done pulse never arrives.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid         per-client request
//   req_write         per-client direction (1 = write to DDR)
//   req_addr          per-client DDR address
//   req_len           per-client length in bursts
//   hp_en, hp_client  high-priority enable and client id
//   err_clr           clears timeout_err
//   req_ready         one-hot, one-cycle accept pulse back to the granted client
//   cmd_valid         command offered to mem_ctrl
//   cmd_ready         mem_ctrl accepts the command
//   cmd_write         command direction
//   read_addr_ddr     read address (0 for writes)
//   write_addr_ddr    write address (0 for reads)
//   cmd_len           command length, forwarded unmodified
//   client_priority   id of the granted client
//   xfer_done         one-cycle completion pulse from mem_ctrl
//   busy              high whenever the arbiter is not idle
//   timeout_err       sticky watchdog error
// ---------------------------------------------------------------------------
module mem_client_arb #(
    parameter int NUM_CLIENTS = 16,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT     = 1024
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CLIENTS-1:0]             req_valid,
    input  logic [NUM_CLIENTS-1:0]             req_write,
    input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_CLIENTS-1:0][LEN_W-1:0]  req_len,
    input  logic                               hp_en,
    input  logic [4:0]                         hp_client,
    input  logic                               err_clr,
    output logic [NUM_CLIENTS-1:0]             req_ready,
    output logic                               cmd_valid,
    input  logic                               cmd_ready,
    output logic                               cmd_write,
    output logic [ADDR_W-1:0]                  read_addr_ddr,
    output logic [ADDR_W-1:0]                  write_addr_ddr,
    output logic [LEN_W-1:0]                   cmd_len,
    output logic [4:0]                         client_priority,
    input  logic                               xfer_done,
    output logic                               busy,
    output logic                               timeout_err
);

    localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [4:0]      RR_INIT = 5'(NUM_CLIENTS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                 state;
    logic [4:0]             rr_ptr;
    logic [WD_W-1:0]        wd_cnt;

    logic [4:0]             rr_start;
    logic [NUM_CLIENTS-1:0] rr_rot;
    logic                   hp_hit;
    logic                   rr_hit;
    logic [4:0]             grant_id;
    logic [NUM_CLIENTS-1:0] grant_onehot;
    logic                   g_write;
    logic [ADDR_W-1:0]      g_addr;
    logic [LEN_W-1:0]       g_len;

    // Grant selection. The request vector is rotated so that bit 0 is the
    // client just after rr_ptr; the lowest set bit of the rotated vector is
    // then the round-robin winner. A high-priority id outside the client
    // range never matches any loop index and is therefore ignored.
    always_comb begin
        rr_start = (int'(rr_ptr) >= NUM_CLIENTS - 1) ? 5'd0 : rr_ptr + 5'd1;
        rr_rot   = NUM_CLIENTS'({req_valid, req_valid} >> rr_start);

        hp_hit = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (hp_en && int'(hp_client) == i && req_valid[i]) begin
                hp_hit = 1'b1;
            end
        end

        rr_hit   = 1'b0;
        grant_id = hp_client;
        if (!hp_hit) begin
            for (int j = 0; j < NUM_CLIENTS; j++) begin
                if (!rr_hit && rr_rot[j]) begin
                    rr_hit   = 1'b1;
                    grant_id = 5'((int'(rr_start) + j) % NUM_CLIENTS);
                end
            end
        end

        grant_onehot = '0;
        g_write      = 1'b0;
        g_addr       = '0;
        g_len        = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (int'(grant_id) == i) begin
                grant_onehot[i] = 1'b1;
                g_write         = req_write[i];
                g_addr          = req_addr[i];
                g_len           = req_len[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            rr_ptr          <= RR_INIT;
            wd_cnt          <= '0;
            req_ready       <= '0;
            cmd_valid       <= 1'b0;
            cmd_write       <= 1'b0;
            read_addr_ddr   <= '0;
            write_addr_ddr  <= '0;
            cmd_len         <= '0;
            client_priority <= '0;
            busy            <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            // Accept pulse lasts exactly one cycle.
            req_ready <= '0;

            // A timeout raised below in the same cycle overrides this clear.
            if (err_clr) begin
                timeout_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        state           <= ISSUE;
                        busy            <= 1'b1;
                        req_ready       <= grant_onehot;
                        cmd_valid       <= 1'b1;
                        cmd_write       <= g_write;
                        read_addr_ddr   <= g_write ? '0 : g_addr;
                        write_addr_ddr  <= g_write ? g_addr : '0;
                        cmd_len         <= g_len;
                        client_priority <= grant_id;
                        rr_ptr          <= grant_id;
                    end
                end

                ISSUE: begin
                    // xfer_done before the command is accepted is ignored.
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        if (xfer_done) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state  <= WAIT;
                            wd_cnt <= '0;
                        end
                    end
                end

                WAIT: begin
                    // Completion on the expiry cycle wins over the watchdog.
                    if (xfer_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (wd_cnt == WD_LAST) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_client_arb.md
Name: mem_client_arb

Overview:
- Arbitrates up to NUM_CLIENTS compute clients (conv/pool/FC engines) for the single DDR<->SRAM transfer engine (mem_ctrl).
- Selects one request at a time, with an optional high-priority client and round-robin among the rest.
- Drives the selected command (read/write address, length, client id) to mem_ctrl through a valid/ready handshake, then holds off until the transfer-done indication.
- A watchdog flags transfers that never complete.

Parameters:
- NUM_CLIENTS, 16: number of requesters (max 32, since the client id is 5 bits).
- ADDR_W, 32: DDR address width.
- LEN_W, 8: transfer length field width, in bursts.
- TIMEOUT, 1024: maximum cycles allowed in WAIT before an error is flagged.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_CLIENTS  per-client request.
- req_write  in  NUM_CLIENTS  1=write to DDR, 0=read from DDR.
- req_addr  in  [NUM_CLIENTS][ADDR_W]  per-client DDR address.
- req_len  in  [NUM_CLIENTS][LEN_W]  per-client length.
- hp_en  in  1  enables the high-priority client.
- hp_client  in  5  high-priority client id.
- err_clr  in  1  clears timeout_err.
- req_ready  out  NUM_CLIENTS  one-hot, one-cycle accept pulse.
- cmd_valid  out  1  command valid to mem_ctrl.
- cmd_ready  in  1  mem_ctrl accepts the command.
- cmd_write  out  1  command direction.
- read_addr_ddr  out  ADDR_W  read address (0 when cmd_write=1).
- write_addr_ddr  out  ADDR_W  write address (0 when cmd_write=0).
- cmd_len  out  LEN_W  command length.
- client_priority  out  5  granted client id.
- xfer_done  in  1  one-cycle pulse from mem_ctrl when the transfer completes.
- busy  out  1  high whenever state != IDLE.
- timeout_err  out  1  sticky watchdog error.

Behaviour:
- All outputs are registered. Reset values:
  - All outputs 0.
  - Round-robin pointer rr_ptr = NUM_CLIENTS-1, so client 0 wins first.
  - State IDLE.
- Reset asserted in any state returns to IDLE on the next edge. Any in-flight command is abandoned with no req_ready.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, at an edge where any req_valid is set, grants one client:
  - If hp_en=1, hp_client < NUM_CLIENTS and req_valid[hp_client]=1, grant hp_client.
  - Otherwise grant the first set bit searching rr_ptr+1, rr_ptr+2, ... with wrap modulo NUM_CLIENTS.
  - hp_client >= NUM_CLIENTS is ignored.
  - On grant, latch the client's write, addr and len into the command registers. Set client_priority = id, rr_ptr = id (also on a high-priority grant), and go to ISSUE.
- Entry into ISSUE:
  - req_ready[id] = 1 for exactly the first ISSUE cycle, 0 otherwise. The request is accepted in the cycle after it was sampled.
  - Clients hold req_* stable until they see req_ready; they may drop or re-raise afterwards.
  - A request withdrawn in IDLE before sampling is never granted.
- ISSUE:
  - cmd_valid=1, with command fields stable, until cmd_ready is sampled high.
  - cmd_ready=1 and xfer_done=1 in the same cycle: go to IDLE.
  - cmd_ready=1 alone: go to WAIT.
  - xfer_done without cmd_ready is ignored.
  - cmd_valid drops in the cycle after the handshake.
- WAIT:
  - Watchdog counter wd_cnt starts at 0 on entry and increments each cycle.
  - xfer_done=1: go to IDLE.
  - Else, wd_cnt == TIMEOUT-1: set timeout_err and go to IDLE.
  - xfer_done in the same cycle as expiry: done wins and no error is set.
- Back-to-back: a new grant may be decided at the first IDLE edge. Minimum spacing between cmd_valid assertions is 2 cycles after the handshake.
- timeout_err is sticky. It is cleared by err_clr or rst, and err_clr has lower priority than a same-cycle new timeout.
- cmd_len is forwarded unmodified; len=0 is passed through and not interpreted.
- Command fields (including client_priority) hold their values after completion until the next grant.

Test Plan:
- Single request: client 3 requests a read, addr=0x1000_0040, len=4; cmd_ready at the 2nd ISSUE cycle; xfer_done 5 cycles later. Required:
  - req_ready[3] pulses once.
  - read_addr_ddr=0x1000_0040, write_addr_ddr=0, client_priority=3, cmd_len=4.
  - busy drops the cycle after xfer_done.
- Round-robin: clients 0, 5 and 15 request continuously, hp_en=0, immediate cmd_ready and xfer_done. Required: grant order 0, 5, 15, 0, 5, ...; no client is granted twice before the others.
- Priority: hp_en=1, hp_client=5, clients 2 and 5 continuously requesting. Required:
  - Client 5 wins every arbitration.
  - hp_client=20 with NUM_CLIENTS=16 is ignored and clients 2 and 5 alternate.
- Handshake corners: cmd_ready held low for 10 cycles. Required: cmd_valid and fields stay stable and req_ready pulses only once. Then cmd_ready and xfer_done in the same cycle. Required: direct ISSUE->IDLE.
- Watchdog: TIMEOUT=16, xfer_done never arrives. Required:
  - timeout_err set after exactly 16 WAIT cycles; state returns to IDLE.
  - err_clr clears it.
  - A repeat with xfer_done exactly at cycle 16 leaves timeout_err=0.
- Reset mid-operation: rst in WAIT with other requests pending. Required:
  - All outputs are 0 the next cycle.
  - rr_ptr is reinitialised, so client 0 wins if requesting.
